// File: rtl/xaui_rx_sync_pkg.sv
// Shared constants and state encodings for the XAUI receive lane-sync / deskew block.
package xaui_rx_sync_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam int unsigned NUM_LANES = 4;

   typedef enum logic [2:0] {
      LS_LOS, LS_CD1, LS_CD2, LS_CD3, LS_SA1, LS_SA2, LS_SA3, LS_SA4
   } lane_state_e;

   typedef enum logic [2:0] {
      AS_LOA, AS_AD, AS_AA1, AS_AA2, AS_AA3
   } align_state_e;

endpackage

// File: rtl/xaui_lane_sync.sv
// Per-lane code-group synchronisation FSM with good-cycle hysteresis and sync-loss pulse.
module xaui_lane_sync
   import xaui_rx_sync_pkg::*;
#(
   parameter int unsigned GOOD_THRESH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] rxdata,
   input  logic [1:0]  rxcharisk,
   input  logic [1:0]  rxcodevalid,
   input  logic        rxbufferr,
   input  logic        rxlock,
   output logic        in_sync,
   output logic        in_acq,
   output logic        loss
);

   localparam int unsigned GW = $clog2(GOOD_THRESH + 1);

   lane_state_e   state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic          loss_q, loss_d;
   logic          comma, bad;

   always_comb begin
      comma = 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
         if (rxdata[b*8 +: 8] == K28_5 && rxcharisk[b] && rxcodevalid[b]) comma = 1'b1;
      end
      bad = rxbufferr || (rxcodevalid != 2'b11);
   end

   always_comb begin
      state_d = state_q;
      good_d  = '0;
      case (state_q)
         LS_LOS, LS_CD1, LS_CD2, LS_CD3: begin
            if (bad)        state_d = LS_LOS;
            else if (comma) state_d = lane_state_e'(state_q + 3'd1);
         end
         LS_SA1: begin
            if (bad) state_d = LS_SA2;
         end
         LS_SA2, LS_SA3, LS_SA4: begin
            if (bad)
               state_d = (state_q == LS_SA4) ? LS_LOS : lane_state_e'(state_q + 3'd1);
            else if (good_q == GW'(GOOD_THRESH - 1))
               state_d = lane_state_e'(state_q - 3'd1);
            else
               good_d = good_q + 1'b1;
         end
         default: state_d = LS_LOS;
      endcase
      if (!rxlock) begin
         state_d = LS_LOS;
         good_d  = '0;
      end
      loss_d = (state_q >= LS_SA1) && (state_d == LS_LOS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LS_LOS;
         good_q  <= '0;
         loss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         loss_q  <= loss_d;
      end
   end

   assign in_sync = (state_q >= LS_SA1);
   assign in_acq  = !in_sync;
   assign loss    = loss_q;

endmodule

// File: rtl/xaui_rx_sync.sv
// XAUI receive port: four lane-sync FSMs, ||A|| column deskew FSM, sync-loss counter.
module xaui_rx_sync
   import xaui_rx_sync_pkg::*;
#(
   parameter int unsigned GOOD_THRESH  = 4,
   parameter int unsigned ALIGN_THRESH = 4
) (
   input  logic        xaui_clk,
   input  logic        xaui_rst_n,
   input  logic [63:0] mgt_rxdata,
   input  logic [7:0]  mgt_rxcharisk,
   input  logic [7:0]  mgt_rxcodevalid,
   input  logic [3:0]  mgt_rxbufferr,
   input  logic [3:0]  mgt_rxlock,
   output logic [3:0]  mgt_rxencommaalign,
   output logic        mgt_rxenchansync,
   output logic [3:0]  lane_sync,
   output logic        align_status,
   output logic [15:0] sync_loss_cnt,
   input  logic        cnt_clr
);

   localparam int unsigned ACNT_MAX = (ALIGN_THRESH > 2) ? ALIGN_THRESH : 2;
   localparam int unsigned AW       = $clog2(ACNT_MAX + 1);

   logic [1:0] rst_pipe_q, rst_pipe_d;
   logic       rst_sync_n;

   // Assert asynchronously, release two edges after xaui_rst_n rises.
   always_comb rst_pipe_d = {rst_pipe_q[0], 1'b1};

   always_ff @(posedge xaui_clk or negedge xaui_rst_n) begin
      if (!xaui_rst_n) rst_pipe_q <= '0;
      else             rst_pipe_q <= rst_pipe_d;
   end

   assign rst_sync_n = rst_pipe_q[1];

   logic [3:0] lane_in_sync, lane_in_acq, lane_loss;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      xaui_lane_sync #(.GOOD_THRESH(GOOD_THRESH)) u_lane (
         .clk         (xaui_clk),
         .rst_n       (rst_sync_n),
         .rxdata      (mgt_rxdata[l*16 +: 16]),
         .rxcharisk   (mgt_rxcharisk[l*2 +: 2]),
         .rxcodevalid (mgt_rxcodevalid[l*2 +: 2]),
         .rxbufferr   (mgt_rxbufferr[l]),
         .rxlock      (mgt_rxlock[l]),
         .in_sync     (lane_in_sync[l]),
         .in_acq      (lane_in_acq[l]),
         .loss        (lane_loss[l])
      );
   end

   logic [3:0]   a_seen;
   logic         column, misaligned, all_sync;
   align_state_e align_q, align_d;
   logic [AW-1:0] acnt_q, acnt_d;

   always_comb begin
      a_seen = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         a_seen[l] = (mgt_rxdata[l*16 +: 8] == K28_3) && mgt_rxcharisk[l*2];
      end
      column     = &a_seen;
      misaligned = (|a_seen) && !column;
      all_sync   = &lane_in_sync;
   end

   always_comb begin
      align_d = align_q;
      acnt_d  = acnt_q;
      if (!all_sync) begin
         align_d = AS_LOA;
         acnt_d  = '0;
      end else begin
         case (align_q)
            AS_LOA: begin
               if (column) begin
                  align_d = AS_AD;
                  acnt_d  = AW'(1);
               end
            end
            AS_AD: begin
               if (misaligned) begin
                  align_d = AS_LOA;
                  acnt_d  = '0;
               end else if (column) begin
                  if (acnt_q == AW'(ALIGN_THRESH - 1)) begin
                     align_d = AS_AA1;
                     acnt_d  = '0;
                  end else begin
                     acnt_d = acnt_q + 1'b1;
                  end
               end
            end
            AS_AA1, AS_AA2, AS_AA3: begin
               if (misaligned) begin
                  align_d = (align_q == AS_AA3) ? AS_LOA : align_state_e'(align_q + 3'd1);
                  acnt_d  = '0;
               end else if (column) begin
                  if (acnt_q == AW'(1)) begin
                     acnt_d = '0;
                     if (align_q != AS_AA1) align_d = align_state_e'(align_q - 3'd1);
                  end else begin
                     acnt_d = acnt_q + 1'b1;
                  end
               end
            end
            default: begin
               align_d = AS_LOA;
               acnt_d  = '0;
            end
         endcase
      end
   end

   logic [3:0]  lane_sync_q, lane_sync_d;
   logic [3:0]  encomma_q, encomma_d;
   logic        chansync_q, chansync_d;
   logic        align_status_q, align_status_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  loss_sum;
   logic [16:0] cnt_sum;

   always_comb begin
      loss_sum = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) loss_sum = loss_sum + {2'b00, lane_loss[l]};
      cnt_sum        = {1'b0, cnt_q} + {14'd0, loss_sum};
      cnt_d          = cnt_clr ? '0 : (cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0]);
      lane_sync_d    = lane_in_sync;
      encomma_d      = lane_in_acq;
      chansync_d     = all_sync && (align_q == AS_LOA || align_q == AS_AD);
      align_status_d = align_q inside {AS_AA1, AS_AA2, AS_AA3};
   end

   always_ff @(posedge xaui_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         align_q        <= AS_LOA;
         acnt_q         <= '0;
         lane_sync_q    <= '0;
         encomma_q      <= '1;
         chansync_q     <= 1'b0;
         align_status_q <= 1'b0;
         cnt_q          <= '0;
      end else begin
         align_q        <= align_d;
         acnt_q         <= acnt_d;
         lane_sync_q    <= lane_sync_d;
         encomma_q      <= encomma_d;
         chansync_q     <= chansync_d;
         align_status_q <= align_status_d;
         cnt_q          <= cnt_d;
      end
   end

   assign lane_sync          = lane_sync_q;
   assign mgt_rxencommaalign = encomma_q;
   assign mgt_rxenchansync   = chansync_q;
   assign align_status       = align_status_q;
   assign sync_loss_cnt      = cnt_q;

endmodule
